dma_mem_bank: RTL and testbench

Dual-bank 256-bit on-chip buffer that sits directly downstream of the DMA engine. It accepts 256-bit words assembled from SDRAM beats, stores them in one of two ping-pong banks, and reports per-bank readiness back to the DMA. It also provides a locked read port to the CNN compute array, so one bank can be consumed while the DMA fills the other.

---
 rtl/dma_mem_bank_if.sv | 48 ++++
 rtl/dma_mem_bank.sv | 156 +++++++++++++++
 tb/tb_dma_mem_bank.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_mem_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_bank_if
// Purpose  : Bus bundle between the DMA engine / CNN array (master side) and
//            the dual-bank ping-pong buffer (slave side).
// Signals  : mem_enable[1:0]   DMA command (00 idle, 01 read, 10 write, 11 idle)
//            mem_selecter      DMA bank select (0 = bank1, 1 = bank2)
//            mem1_addr/mem2_addr  per-bank DMA word address
//            mem_data_in/out   DMA write data / registered read data
//            memory1_ready/memory2_ready  per-bank idle indication
//            cnn_lock[1:0]     per-bank lock request (bit0 = bank1)
//            cnn_rd_en/cnn_bank/cnn_addr  CNN read strobe, bank, address
//            cnn_rd_data/cnn_rd_valid     CNN read data and qualifier
//            wr_drop_err       sticky dropped-write flag
// Revision : 1.0 - initial release
// ============================================================================
interface dma_mem_bank_if;
    logic [1:0]   mem_enable;
    logic         mem_selecter;
    logic [5:0]   mem1_addr;
    logic [5:0]   mem2_addr;
    logic [255:0] mem_data_in;
    logic [255:0] mem_data_out;
    logic         memory1_ready;
    logic         memory2_ready;
    logic [1:0]   cnn_lock;
    logic         cnn_rd_en;
    logic         cnn_bank;
    logic [5:0]   cnn_addr;
    logic [255:0] cnn_rd_data;
    logic         cnn_rd_valid;
    logic         wr_drop_err;

    modport master (
        output mem_enable, mem_selecter, mem1_addr, mem2_addr, mem_data_in,
        output cnn_lock, cnn_rd_en, cnn_bank, cnn_addr,
        input  mem_data_out, memory1_ready, memory2_ready,
        input  cnn_rd_data, cnn_rd_valid, wr_drop_err
    );

    modport slave (
        input  mem_enable, mem_selecter, mem1_addr, mem2_addr, mem_data_in,
        input  cnn_lock, cnn_rd_en, cnn_bank, cnn_addr,
        output mem_data_out, memory1_ready, memory2_ready,
        output cnn_rd_data, cnn_rd_valid, wr_drop_err
    );
endinterface
`default_nettype wire

// File: rtl/dma_mem_bank.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_bank
// Purpose  : Dual-bank 256-bit ping-pong buffer. The DMA fills/reads a bank
//            while it is idle; the CNN array reads a bank while it holds it
//            locked. Each bank has its own IDLE/WRITE/LOCKED controller with a
//            post-write busy counter of WR_LAT cycles.
// Ports    : clk_h  - clock
//            rst_n  - synchronous active-low reset
//            bus    - dma_mem_bank_if slave modport (DMA + CNN bus)
// Revision : 1.0 - initial release
// ============================================================================
module dma_mem_bank #(
    parameter int DEPTH  = 64,
    parameter int WR_LAT = 2
) (
    input  logic           clk_h,
    input  logic           rst_n,
    dma_mem_bank_if.slave  bus
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(WR_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Out-of-range addresses alias back into the bank.
    function automatic logic [AW-1:0] wrap_addr(input logic [5:0] a);
        logic [6:0] t;
        t = {1'b0, a} % 7'(DEPTH);
        return AW'(t);
    endfunction

    logic [255:0]  r_ram [2][DEPTH];

    logic [1:0]    w_idle;
    logic [1:0]    w_locked;
    logic [1:0]    w_wr_hit;
    logic [1:0]    w_wr_accept;
    logic [1:0]    w_wr_drop;
    logic [AW-1:0] w_addr1;
    logic [AW-1:0] w_addr2;
    logic [AW-1:0] w_dma_rd_addr;
    logic [AW-1:0] w_cnn_addr;

    logic [255:0]  r_mem_data_out;
    logic [255:0]  r_cnn_rd_data;
    logic          r_cnn_rd_valid;
    logic          r_wr_drop_err;

    assign w_addr1       = wrap_addr(bus.mem1_addr);
    assign w_addr2       = wrap_addr(bus.mem2_addr);
    assign w_dma_rd_addr = bus.mem_selecter ? w_addr2 : w_addr1;
    assign w_cnn_addr    = wrap_addr(bus.cnn_addr);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;

        assign w_wr_hit[b] = (bus.mem_enable == 2'b10) && (bus.mem_selecter == 1'(b));

        always_ff @(posedge clk_h) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // A write seen in IDLE wins over a lock request in the same cycle;
        // the lock is then honoured when the busy window closes.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_hit[b]) begin
                        w_state_nxt = ST_WRITE;
                        w_cnt_nxt   = CNT_W'(WR_LAT);
                    end else if (bus.cnn_lock[b]) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_WRITE: begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = bus.cnn_lock[b] ? ST_LOCKED : ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (!bus.cnn_lock[b]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_idle[b]      = (r_state == ST_IDLE);
        assign w_locked[b]    = (r_state == ST_LOCKED);
        // Gating with rst_n keeps a write presented during reset out of RAM.
        assign w_wr_accept[b] = w_wr_hit[b] && w_idle[b] && rst_n;
        assign w_wr_drop[b]   = w_wr_hit[b] && !w_idle[b];
    end

    // RAM has no reset: contents survive rst_n.
    always_ff @(posedge clk_h) begin
        if (w_wr_accept[0]) begin
            r_ram[0][w_addr1] <= bus.mem_data_in;
        end
        if (w_wr_accept[1]) begin
            r_ram[1][w_addr2] <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            r_mem_data_out <= '0;
            r_cnn_rd_data  <= '0;
            r_cnn_rd_valid <= 1'b0;
            r_wr_drop_err  <= 1'b0;
        end else begin
            if ((bus.mem_enable == 2'b01) && w_idle[bus.mem_selecter]) begin
                r_mem_data_out <= r_ram[bus.mem_selecter][w_dma_rd_addr];
            end
            r_cnn_rd_valid <= 1'b0;
            if (bus.cnn_rd_en && w_locked[bus.cnn_bank]) begin
                r_cnn_rd_data  <= r_ram[bus.cnn_bank][w_cnn_addr];
                r_cnn_rd_valid <= 1'b1;
            end
            if (|w_wr_drop) begin
                r_wr_drop_err <= 1'b1;
            end
        end
    end

    assign bus.mem_data_out  = r_mem_data_out;
    assign bus.memory1_ready = w_idle[0];
    assign bus.memory2_ready = w_idle[1];
    assign bus.cnn_rd_data   = r_cnn_rd_data;
    assign bus.cnn_rd_valid  = r_cnn_rd_valid;
    assign bus.wr_drop_err   = r_wr_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_mem_bank
// Purpose  : Self-checking bench for dma_mem_bank. A behavioural model tracks
//            per-bank busy time, lock ownership, RAM contents and output
//            registers; a negedge process compares every output each cycle.
//            Directed sequences pin the model with literal expectations, then
//            randomized traffic runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_mem_bank;

    localparam int DEPTH  = 64;
    localparam int WR_LAT = 2;

    logic clk_h = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk_h = ~clk_h;

    dma_mem_bank_if bus ();

    dma_mem_bank #(
        .DEPTH  (DEPTH),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk_h (clk_h),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Behavioural model: a bank is ready when no write time is left and
    // the CNN does not own it.
    // ------------------------------------------------------------------
    logic [255:0] m_ram   [2][DEPTH];
    bit           m_known [2][DEPTH];
    int           m_busy  [2];
    bit           m_locked[2];
    logic [255:0] m_out;
    logic [255:0] m_cnn;
    bit           m_out_known;
    bit           m_cnn_known;
    bit           m_valid;
    bit           m_err;

    bit chk_en = 1'b0;
    int n_vec  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic bit m_ready(input int b);
        return (m_busy[b] == 0) && !m_locked[b];
    endfunction

    always @(posedge clk_h) begin
        bit rdy [2];
        bit lk  [2];
        int sel;
        int addr [2];
        int ca;
        int cb;
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                m_busy[b]   = 0;
                m_locked[b] = 1'b0;
            end
            m_out = '0; m_out_known = 1'b1;
            m_cnn = '0; m_cnn_known = 1'b1;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                rdy[b] = m_ready(b);
                lk[b]  = m_locked[b];
            end
            sel     = int'(bus.mem_selecter);
            addr[0] = int'(bus.mem1_addr) % DEPTH;
            addr[1] = int'(bus.mem2_addr) % DEPTH;
            if (bus.mem_enable == 2'b01 && rdy[sel]) begin
                m_out       = m_ram[sel][addr[sel]];
                m_out_known = m_known[sel][addr[sel]];
            end
            cb = int'(bus.cnn_bank);
            ca = int'(bus.cnn_addr) % DEPTH;
            m_valid = 1'b0;
            if (bus.cnn_rd_en && lk[cb]) begin
                m_cnn       = m_ram[cb][ca];
                m_cnn_known = m_known[cb][ca];
                m_valid     = 1'b1;
            end
            for (int b = 0; b < 2; b++) begin
                if (bus.mem_enable == 2'b10 && sel == b && !rdy[b]) m_err = 1'b1;
                if (bus.mem_enable == 2'b10 && sel == b && rdy[b]) begin
                    m_ram[b][addr[b]]   = bus.mem_data_in;
                    m_known[b][addr[b]] = 1'b1;
                    m_busy[b]           = WR_LAT;
                end else begin
                    if (m_busy[b] > 0) m_busy[b]--;
                    if (m_busy[b] == 0) m_locked[b] = bus.cnn_lock[b];
                end
            end
        end
    end

    // Compare process: every output, every cycle.
    always @(negedge clk_h) begin
        if (chk_en) begin
            check("memory1_ready", {255'd0, bus.memory1_ready}, {255'd0, m_ready(0)});
            check("memory2_ready", {255'd0, bus.memory2_ready}, {255'd0, m_ready(1)});
            check("wr_drop_err",   {255'd0, bus.wr_drop_err},   {255'd0, m_err});
            check("cnn_rd_valid",  {255'd0, bus.cnn_rd_valid},  {255'd0, m_valid});
            if (m_out_known) check("mem_data_out", bus.mem_data_out, m_out);
            if (m_cnn_known) check("cnn_rd_data",  bus.cnn_rd_data,  m_cnn);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change just after a negedge)
    // ------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk_h);
    endtask

    task automatic idle_in();
        bus.mem_enable   = 2'b00;
        bus.mem_selecter = 1'b0;
        bus.mem1_addr    = '0;
        bus.mem2_addr    = '0;
        bus.mem_data_in  = '0;
        bus.cnn_rd_en    = 1'b0;
        bus.cnn_bank     = 1'b0;
        bus.cnn_addr     = '0;
    endtask

    task automatic set_wr(input bit b, input logic [5:0] a, input logic [255:0] d);
        bus.mem_enable   = 2'b10;
        bus.mem_selecter = b;
        bus.mem1_addr    = a;
        bus.mem2_addr    = a;
        bus.mem_data_in  = d;
    endtask

    task automatic set_rd(input bit b, input logic [5:0] a);
        bus.mem_enable   = 2'b01;
        bus.mem_selecter = b;
        bus.mem1_addr    = a;
        bus.mem2_addr    = a;
    endtask

    task automatic dma_write(input bit b, input logic [5:0] a, input logic [255:0] d);
        set_wr(b, a, d);
        cyc();
        idle_in();
        repeat (WR_LAT) cyc();
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [255:0] pat_a5;
    logic [255:0] v_x, v_y, v1, v2, v3;

    initial begin
        idle_in();
        bus.cnn_lock = 2'b00;
        rst_n        = 1'b0;
        pat_a5       = {32{8'hA5}};
        cyc();
        chk_en = 1'b1;
        // Reset state
        check("rst_ready1", {255'd0, bus.memory1_ready}, 256'd1);
        check("rst_ready2", {255'd0, bus.memory2_ready}, 256'd1);
        check("rst_mem_data_out", bus.mem_data_out, 256'd0);
        check("rst_cnn_rd_data",  bus.cnn_rd_data,  256'd0);
        check("rst_cnn_rd_valid", {255'd0, bus.cnn_rd_valid}, 256'd0);
        check("rst_wr_drop_err",  {255'd0, bus.wr_drop_err},  256'd0);
        rst_n = 1'b1;
        cyc();

        // Write A5..A5 to bank1 0x10: ready low for exactly WR_LAT cycles
        set_wr(1'b0, 6'h10, pat_a5);
        cyc(); idle_in();
        check("t1_ready1_c1", {255'd0, bus.memory1_ready}, 256'd0);
        check("t1_ready2",    {255'd0, bus.memory2_ready}, 256'd1);
        cyc();
        check("t1_ready1_c2", {255'd0, bus.memory1_ready}, 256'd0);
        cyc();
        check("t1_ready1_back", {255'd0, bus.memory1_ready}, 256'd1);
        check("t1_err",         {255'd0, bus.wr_drop_err},   256'd0);
        set_rd(1'b0, 6'h10);
        cyc(); idle_in();
        check("t1_readback", bus.mem_data_out, pat_a5);

        // Fill both banks so every later read has a defined value
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                dma_write(b[0], 6'(a), rnd256());

        // Write bank2 addr 5, read it back one cycle later
        v_x = {8{32'h1234_5678}};
        dma_write(1'b1, 6'd5, v_x);
        set_rd(1'b1, 6'd5);
        cyc(); idle_in();
        check("t2_readback", bus.mem_data_out, v_x);

        // Lock and write in the same IDLE cycle: write wins, then LOCKED
        v_y = {4{64'hDEAD_BEEF_0BAD_F00D}};
        bus.cnn_lock[0] = 1'b1;
        set_wr(1'b0, 6'h20, v_y);
        cyc(); idle_in();
        check("t3_ready1_w1", {255'd0, bus.memory1_ready}, 256'd0);
        cyc();
        check("t3_ready1_w2", {255'd0, bus.memory1_ready}, 256'd0);
        cyc();
        check("t3_ready1_lk", {255'd0, bus.memory1_ready}, 256'd0);
        bus.cnn_rd_en = 1'b1; bus.cnn_bank = 1'b0; bus.cnn_addr = 6'h20;
        cyc(); idle_in();
        check("t3_cnn_valid", {255'd0, bus.cnn_rd_valid}, 256'd1);
        check("t3_cnn_data",  bus.cnn_rd_data, v_y);
        bus.cnn_lock[0] = 1'b0;
        cyc();
        check("t3_ready1_unlock", {255'd0, bus.memory1_ready}, 256'd1);

        // Four back-to-back CNN reads on locked bank1, then one to unlocked bank2
        bus.cnn_lock[0] = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus.cnn_rd_en = 1'b1; bus.cnn_bank = 1'b0; bus.cnn_addr = 6'(i);
            cyc();
            check("t4_valid", {255'd0, bus.cnn_rd_valid}, 256'd1);
            check("t4_data",  bus.cnn_rd_data, m_ram[0][i]);
        end
        bus.cnn_rd_en = 1'b1; bus.cnn_bank = 1'b1; bus.cnn_addr = 6'd0;
        cyc(); idle_in();
        check("t4_unlocked_valid", {255'd0, bus.cnn_rd_valid}, 256'd0);
        bus.cnn_lock[0] = 1'b0;
        cyc();

        // Write to bank1 while it is in WRITE: dropped, sticky error
        v1 = {16{16'h1111}};
        v2 = {16{16'h2222}};
        set_wr(1'b0, 6'd7, v1);
        cyc();
        set_wr(1'b0, 6'd7, v2);
        cyc(); idle_in();
        check("t5_err_set", {255'd0, bus.wr_drop_err}, 256'd1);
        cyc();
        set_rd(1'b0, 6'd7);
        cyc(); idle_in();
        check("t5_ram_unchanged", bus.mem_data_out, v1);
        repeat (3) cyc();
        check("t5_err_sticky", {255'd0, bus.wr_drop_err}, 256'd1);

        // Reset in the middle of a write
        v3 = {8{32'hCAFE_0009}};
        set_wr(1'b1, 6'd9, v3);
        cyc(); idle_in();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("t6_ready2", {255'd0, bus.memory2_ready}, 256'd1);
        check("t6_err_clr", {255'd0, bus.wr_drop_err}, 256'd0);
        set_rd(1'b1, 6'd9);
        cyc(); idle_in();
        check("t6_readback", bus.mem_data_out, v3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.mem_enable   = 2'($urandom_range(0, 3));
            bus.mem_selecter = 1'($urandom_range(0, 1));
            bus.mem1_addr    = 6'($urandom);
            bus.mem2_addr    = 6'($urandom);
            bus.mem_data_in  = rnd256();
            if ($urandom_range(0, 7) == 0) bus.cnn_lock[0] = ~bus.cnn_lock[0];
            if ($urandom_range(0, 7) == 0) bus.cnn_lock[1] = ~bus.cnn_lock[1];
            bus.cnn_rd_en    = 1'($urandom_range(0, 1));
            bus.cnn_bank     = 1'($urandom_range(0, 1));
            bus.cnn_addr     = 6'($urandom);
            rst_n            = ($urandom_range(0, 399) != 0);
            cyc();
        end

        idle_in();
        bus.cnn_lock = 2'b00;
        rst_n = 1'b1;
        repeat (4) cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
